// File: rtl/nor_flash_ctrl.sv
// Behavioural NOR flash array behind a single-command controller: read, program (clear-only),
// sector erase and chip erase, with busy/done status and a sticky program-error flag.
module nor_flash_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int SECTOR_W    = 4,
  parameter int PROG_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              prog_err,
  input  logic              err_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PROG_CYCLES - 1);
  localparam logic [ADDR_W-1:0] SEC_MASK = {ADDR_W{1'b1}} >> (ADDR_W - SECTOR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_PROG  = 2'd2,
    S_ERASE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   era_addr_q, era_addr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                chip_q;

  // Stored inverted so that a zero-filled power-up array reads as erased (all ones).
  logic [DATA_W-1:0]   mem_n [DEPTH];

  logic                accept;
  logic [DATA_W-1:0]   cur_word;
  logic [ADDR_W-1:0]   era_mask;
  logic                era_last;
  logic                prog_last;
  logic                prog_we;
  logic                era_we;

  assign accept    = cmd_valid && (state_q == S_IDLE);
  assign cur_word  = ~mem_n[addr_q];
  assign era_mask  = chip_q ? {ADDR_W{1'b1}} : SEC_MASK;
  assign era_last  = ((era_addr_q | ~era_mask) == {ADDR_W{1'b1}});
  assign prog_last = (cnt_q == CNT_LAST);
  assign prog_we   = (state_q == S_PROG) && prog_last;
  assign era_we    = (state_q == S_ERASE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    era_addr_d = era_addr_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          unique case (cmd_op)
            2'b00: begin
              rdata_d = ~mem_n[cmd_addr];
              state_d = S_READ;
            end
            2'b01: state_d = S_PROG;
            2'b10: begin
              era_addr_d = cmd_addr & ~SEC_MASK;
              state_d    = S_ERASE;
            end
            default: begin
              era_addr_d = '0;
              state_d    = S_ERASE;
            end
          endcase
        end
      end
      S_READ: state_d = S_IDLE;
      S_PROG: begin
        if (prog_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERASE: begin
        // The counter stops on the final word, so it never wraps past the end of the array.
        if (era_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          era_addr_d = era_addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_clr) begin
      err_d = 1'b0;
    end
    if (prog_we && ((wdata_q & ~cur_word) != '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      era_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      era_addr_q <= era_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      chip_q  <= (cmd_op == 2'b11);
    end
  end

  // Writes are qualified by the reset-cleared state, so an aborted operation stops writing at once.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_n[addr_q] <= ~(cur_word & wdata_q);
    end else if (era_we) begin
      mem_n[era_addr_q] <= '0;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_PROG) || (state_q == S_ERASE);
  assign rvalid    = (state_q == S_READ);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign prog_err  = err_q;

endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Self-checking bench for nor_flash_ctrl: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_nor_flash_ctrl;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int SECTOR_W    = 4;
  localparam int PROG_CYCLES = 4;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam int SEC_SIZE    = 1 << SECTOR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              done;
  logic              prog_err;
  logic              err_clr;

  logic [DATA_W-1:0] model [DEPTH];
  logic              m_err;
  int                n_checks = 0;
  int                n_errs   = 0;

  nor_flash_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SECTOR_W(SECTOR_W), .PROG_CYCLES(PROG_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rdata(rdata),
    .rvalid(rvalid), .busy(busy), .done(done), .prog_err(prog_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) check("done_rvalid_excl", {31'b0, done & rvalid}, 32'd0);
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    int t = 0;
    while (!cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("issue_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_busy(input int exp_cycles, input string tag);
    int n = 0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_not_ready"}, cmd_ready, 0);
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_done"}, done, 1);
    check({tag, "_ready_at_done"}, cmd_ready, 1);
  endtask

  task automatic do_read(input logic [7:0] a);
    issue(2'b00, a, 8'($urandom));
    check("rvalid", rvalid, 1);
    check("rdata", rdata, model[a]);
    check("read_busy", busy, 0);
    @(negedge clk);
    check("rvalid_pulse", rvalid, 0);
  endtask

  task automatic do_prog(input logic [7:0] a, input logic [7:0] d);
    issue(2'b01, a, d);
    wait_busy(PROG_CYCLES, "prog");
    if ((d & ~model[a]) != 8'h00) m_err = 1'b1;
    model[a] = model[a] & d;
    check("prog_err", prog_err, m_err);
    @(negedge clk);
    check("prog_done_pulse", done, 0);
  endtask

  task automatic do_erase(input logic [7:0] a, input bit chip);
    int base;
    int len;
    issue(chip ? 2'b11 : 2'b10, a, 8'($urandom));
    base = chip ? 0 : (int'(a) / SEC_SIZE) * SEC_SIZE;
    len  = chip ? DEPTH : SEC_SIZE;
    wait_busy(len, chip ? "chip_erase" : "sec_erase");
    for (int i = base; i < base + len; i++) model[i] = 8'hFF;
    @(negedge clk);
    check("erase_done_pulse", done, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err   = 1'b0;
    check("err_clr", prog_err, 0);
  endtask

  initial begin
    int n;
    bit rdy_seen;
    logic [7:0] pat [7];
    pat = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < DEPTH; i++) model[i] = 8'hFF;
    m_err     = 1'b0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_wdata = '0;
    err_clr   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_prog_err", prog_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Erased read, then programming a run of words
    do_read(8'h01);
    check("erased_0x01", rdata, 8'hFF);
    for (int i = 0; i < 7; i++) begin
      do_prog(8'(i + 1), pat[i]);
      do_read(8'(i + 1));
      check("prog_readback", rdata, pat[i]);
    end
    check("no_err_after_clean_progs", prog_err, 0);

    // Clear-only program and sticky error
    do_prog(8'h01, 8'hCD);
    do_read(8'h01);
    check("and_result", rdata, 8'h89);
    repeat (3) @(negedge clk);
    check("err_sticky", prog_err, 1);
    pulse_clr();
    do_prog(8'h01, 8'h01);
    check("no_err_subset", prog_err, 0);
    do_read(8'h01);
    check("subset_result", rdata, 8'h01);

    // Sector erase leaves neighbouring sectors alone; chip erase clears everything
    do_prog(8'h02, 8'h00);
    do_prog(8'h12, 8'h00);
    do_erase(8'h05, 1'b0);
    do_read(8'h02);
    check("sector_erased", rdata, 8'hFF);
    do_read(8'h12);
    check("other_sector_kept", rdata, 8'h00);
    do_erase(8'h77, 1'b1);
    do_read(8'h12);
    check("chip_erased", rdata, 8'hFF);

    // A command held during erase is accepted exactly once when ready returns
    issue(2'b10, 8'h35, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_addr  = 8'h33;
    cmd_wdata = 8'h5A;
    n = 0;
    rdy_seen = 1'b0;
    while (busy && n < 2000) begin
      if (cmd_ready) rdy_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    check("held_erase_cycles", n, SEC_SIZE);
    check("held_no_early_ready", rdy_seen, 0);
    check("held_done", done, 1);
    for (int i = 8'h30; i < 8'h40; i++) model[i] = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_busy(PROG_CYCLES, "held_prog");
    model[8'h33] = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check("held_once", busy, 0);
    end
    do_read(8'h33);

    // Reset during a sector erase
    for (int i = 8'h20; i < 8'h30; i++) do_prog(8'(i), 8'h00);
    issue(2'b10, 8'h2A, 8'h00);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_err = 1'b0;
    for (int i = 8'h20; i < 8'h25; i++) model[i] = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    for (int i = 8'h20; i < 8'h30; i++) do_read(8'(i));

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      int sel;
      logic [7:0] a;
      sel = $urandom_range(0, 11);
      a   = 8'($urandom);
      if (sel < 5) do_read(a);
      else if (sel < 10) do_prog(a, 8'($urandom));
      else if (sel == 10) do_erase(a, 1'b0);
      else pulse_clr();
    end
    check("final_prog_err", prog_err, m_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
